// File: rtl/channel_readout_sequencer.sv
// Walks the enabled Channel FPGAs in ascending order and grants the shared readout bus to one at a time.
// Accumulates each channel's burst count and closes the event with a readout_done/readout_size handshake.
module channel_readout_sequencer #(
   parameter int          NCHAN   = 5,
   parameter logic [23:0] TIMEOUT = 24'd12_500_000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [NCHAN-1:0] chan_en,
   input  logic             initiate_readout,
   input  logic             send_empty_event,
   output logic             readout_ready,
   output logic             readout_done,
   output logic [21:0]      readout_size,
   output logic [NCHAN-1:0] chan_req,
   input  logic [NCHAN-1:0] chan_done,
   input  logic [22:0]      chan_bursts,
   output logic [2:0]       state,
   output logic [31:0]      timeout_count,
   output logic             error_timeout
);
   localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SELECT = 3'd1,
      S_GRANT  = 3'd2,
      S_WAIT   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [NCHAN-1:0] pending_q, pending_d;
   logic [CW-1:0]    cur_q, cur_d;
   logic [23:0]      timer_q, timer_d;
   logic [23:0]      acc_q, acc_d;
   logic [31:0]      tocnt_q, tocnt_d;
   logic             err_q, err_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic [21:0]      size_q, size_d;
   logic [NCHAN-1:0] req_q, req_d;

   logic             accept;
   logic             got_done;
   logic             expired;
   logic [CW-1:0]    lowest;

   function automatic logic [21:0] sat22(input logic [23:0] v);
      return (v > 24'h3FFFFF) ? 22'h3FFFFF : v[21:0];
   endfunction

   function automatic logic [NCHAN-1:0] onehot(input logic [CW-1:0] idx);
      return NCHAN'(1) << idx;
   endfunction

   assign accept   = (state_q == S_IDLE) && ready_q;
   assign got_done = chan_done[cur_q];
   assign expired  = (timer_q == (TIMEOUT - 24'd1));

   always_comb begin
      lowest = '0;
      for (int i = NCHAN - 1; i >= 0; i--) begin
         if (pending_q[i]) lowest = CW'(i);
      end
   end

   // State and control registers; every output is a registered copy of the current state's decode
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         pending_q <= '0;
         tocnt_q   <= '0;
         err_q     <= 1'b0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         size_q    <= '0;
         req_q     <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         tocnt_q   <= tocnt_d;
         err_q     <= err_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         size_q    <= size_d;
         req_q     <= req_d;
      end
   end

   always_ff @(posedge clk) begin
      cur_q   <= cur_d;
      timer_q <= timer_d;
      acc_q   <= acc_d;
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      cur_d     = cur_q;
      timer_d   = timer_q;
      acc_d     = acc_q;
      tocnt_d   = tocnt_q;
      err_d     = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept && initiate_readout) begin
               pending_d = chan_en;
               acc_d     = '0;
               state_d   = S_SELECT;
            end else if (accept && send_empty_event) begin
               acc_d   = '0;
               state_d = S_DONE;
            end
         end
         S_SELECT: begin
            if (pending_q == '0) begin
               state_d = S_DONE;
            end else begin
               cur_d   = lowest;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            timer_d = timer_q + 24'd1;
            // A done in the same cycle as expiry takes priority over the timeout
            if (got_done) begin
               acc_d            = acc_q + {1'b0, chan_bursts};
               pending_d[cur_q] = 1'b0;
               state_d          = S_SELECT;
            end else if (expired) begin
               pending_d[cur_q] = 1'b0;
               if (tocnt_q != 32'hFFFF_FFFF) tocnt_d = tocnt_q + 32'd1;
               err_d   = 1'b1;
               state_d = S_SELECT;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ready_d = (state_q == S_IDLE);
      done_d  = (state_q == S_DONE);
      req_d   = (state_q == S_WAIT) ? onehot(cur_q) : '0;
      size_d  = (state_q == S_DONE) ? sat22(acc_q) : size_q;
   end

   assign readout_ready = ready_q;
   assign readout_done  = done_q;
   assign readout_size  = size_q;
   assign chan_req      = req_q;
   assign state         = state_q;
   assign timeout_count = tocnt_q;
   assign error_timeout = err_q;

endmodule

// File: tb/tb_channel_readout_sequencer.sv
// Scoreboard bench: stimulus predicts grant order and event totals from the enabled mask and per-channel
// behaviour; an independent monitor checks grants, event results and handshake latencies.
module tb_channel_readout_sequencer;
   localparam int          NCHAN = 5;
   localparam logic [23:0] TMO   = 24'd16;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [NCHAN-1:0] chan_en;
   logic             initiate_readout;
   logic             send_empty_event;
   logic             readout_ready;
   logic             readout_done;
   logic [21:0]      readout_size;
   logic [NCHAN-1:0] chan_req;
   logic [NCHAN-1:0] chan_done;
   logic [22:0]      chan_bursts;
   logic [2:0]       state;
   logic [31:0]      timeout_count;
   logic             error_timeout;

   channel_readout_sequencer #(.NCHAN(NCHAN), .TIMEOUT(TMO)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .chan_en          (chan_en),
      .initiate_readout (initiate_readout),
      .send_empty_event (send_empty_event),
      .readout_ready    (readout_ready),
      .readout_done     (readout_done),
      .readout_size     (readout_size),
      .chan_req         (chan_req),
      .chan_done        (chan_done),
      .chan_bursts      (chan_bursts),
      .state            (state),
      .timeout_count    (timeout_count),
      .error_timeout    (error_timeout)
   );

   always #4 clk = ~clk;

   typedef struct {
      int          ngr;
      bit          empty;
      logic [21:0] size;
      logic [31:0] toc;
      logic        err;
   } ev_t;

   ev_t  ev_q[$];
   int   gq[$];
   int   checks = 0;
   int   errors = 0;

   int          cfg_delay[NCHAN];
   logic [22:0] cfg_burst[NCHAN];
   bit          cfg_to[NCHAN];
   bit          cfg_spur[NCHAN];
   logic [31:0] m_toc;
   logic        m_err;

   task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cfg_default();
      for (int i = 0; i < NCHAN; i++) begin
         cfg_delay[i] = 10;
         cfg_burst[i] = '0;
         cfg_to[i]    = 1'b0;
         cfg_spur[i]  = 1'b0;
      end
   endtask

   task automatic cfg_random();
      for (int i = 0; i < NCHAN; i++) begin
         cfg_delay[i] = $urandom_range(1, 15);
         cfg_burst[i] = ($urandom_range(0, 9) == 0) ? 23'h7FFFFF : 23'($urandom_range(0, 5000));
         cfg_to[i]    = ($urandom_range(0, 7) == 0);
         cfg_spur[i]  = (cfg_delay[i] >= 3) && ($urandom_range(0, 3) == 0);
      end
   endtask

   // kind: 0 = initiate, 1 = empty event, 2 = both pulses together (initiate must win)
   task automatic issue(input logic [NCHAN-1:0] mask, input int kind, input bit scramble);
      ev_t    e;
      longint sum;
      int     n;
      e.ngr   = 0;
      e.empty = (kind == 1);
      sum     = 0;
      if (kind != 1) begin
         for (int i = 0; i < NCHAN; i++) begin
            if (mask[i]) begin
               gq.push_back(i);
               e.ngr++;
               if (cfg_to[i]) begin
                  if (m_toc != 32'hFFFF_FFFF) m_toc++;
                  m_err = 1'b1;
               end else begin
                  sum += longint'(cfg_burst[i]);
               end
            end
         end
      end
      e.size = (sum > 64'h3FFFFF) ? 22'h3FFFFF : 22'(sum);
      e.toc  = m_toc;
      e.err  = m_err;
      n = 0;
      while (!readout_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk_eq("ready_before_request", 64'(readout_ready), 64'd1);
      ev_q.push_back(e);
      chan_en          = mask;
      initiate_readout = (kind != 1);
      send_empty_event = (kind != 0);
      @(posedge clk); #1;
      initiate_readout = 1'b0;
      send_empty_event = 1'b0;
      if (scramble) chan_en = NCHAN'($urandom);
   endtask

   task automatic wait_event(input bit noise);
      int n;
      n = 0;
      while ((ev_q.size() != 0 || !readout_ready) && n < 2000) begin
         @(posedge clk); #1;
         n++;
         initiate_readout = 1'b0;
         send_empty_event = 1'b0;
         if (noise && !readout_ready && $urandom_range(0, 5) == 0) begin
            initiate_readout = 1'b1;
            send_empty_event = 1'($urandom_range(0, 1));
         end
      end
      initiate_readout = 1'b0;
      send_empty_event = 1'b0;
      chk_eq("event_completes", 64'(n < 2000), 64'd1);
   endtask

   // Channel model: answers its own grant after cfg_delay cycles, optionally with a stray done on a neighbour
   initial begin : responder
      int c;
      int n;
      chan_done   = '0;
      chan_bursts = '0;
      forever begin
         @(posedge clk); #1;
         if (reset_n && chan_req != '0) begin
            c = 0;
            for (int i = 0; i < NCHAN; i++) if (chan_req[i]) c = i;
            if (!cfg_to[c]) begin
               for (int k = 1; k < cfg_delay[c]; k++) begin
                  @(posedge clk); #1;
                  if (k == 1 && cfg_spur[c]) chan_done = NCHAN'(1) << ((c + 1) % NCHAN);
                  if (k == 2) chan_done = '0;
               end
               chan_done   = NCHAN'(1) << c;
               chan_bursts = cfg_burst[c];
               @(posedge clk); #1;
               chan_done   = '0;
               chan_bursts = 23'($urandom);
            end
            n = 0;
            while (chan_req != '0 && n < 50) begin
               @(posedge clk); #1;
               n++;
            end
         end
      end
   end

   initial begin : monitor
      int         cyc;
      int         rf_cyc;
      int         drop_cyc;
      int         done_cyc;
      int         gseen;
      int         g;
      bit         first_grant;
      bit         rst_checked;
      logic [NCHAN-1:0] prev_req;
      logic       prev_ready;
      ev_t        e;
      cyc = 0; rf_cyc = -100; drop_cyc = -100; done_cyc = -100; gseen = 0;
      first_grant = 1'b1; rst_checked = 1'b0; prev_req = '0; prev_ready = 1'b1;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset_n) begin
            if (!rst_checked) begin
               chk_eq("rst_chan_req", 64'(chan_req), 64'd0);
               chk_eq("rst_readout_done", 64'(readout_done), 64'd0);
               chk_eq("rst_readout_ready", 64'(readout_ready), 64'd1);
               chk_eq("rst_state", 64'(state), 64'd0);
               chk_eq("rst_readout_size", 64'(readout_size), 64'd0);
               chk_eq("rst_timeout_count", 64'(timeout_count), 64'd0);
               chk_eq("rst_error_timeout", 64'(error_timeout), 64'd0);
               rst_checked = 1'b1;
            end
            prev_req = '0; prev_ready = 1'b1; first_grant = 1'b1; gseen = 0;
            rf_cyc = -100; drop_cyc = -100; done_cyc = -100;
         end else begin
            rst_checked = 1'b0;
            if (prev_ready && !readout_ready) begin
               rf_cyc      = cyc;
               first_grant = 1'b1;
               gseen       = 0;
            end
            if (chan_req != prev_req) begin
               if (chan_req == '0) begin
                  drop_cyc = cyc;
               end else begin
                  chk_eq("req_onehot", 64'($onehot(chan_req)), 64'd1);
                  chk_eq("req_zero_before_grant", 64'(prev_req), 64'd0);
                  chk_eq("grant_expected", 64'(gq.size() != 0), 64'd1);
                  if (gq.size() != 0) begin
                     g = gq.pop_front();
                     chk_eq("grant_channel", 64'(chan_req), 64'(NCHAN'(1) << g));
                  end
                  chk_eq("grant_latency", 64'(cyc - (first_grant ? rf_cyc : drop_cyc)), 64'd2);
                  first_grant = 1'b0;
                  gseen++;
               end
            end
            if (readout_done) begin
               chk_eq("done_expected", 64'(ev_q.size() != 0), 64'd1);
               if (ev_q.size() != 0) begin
                  e = ev_q.pop_front();
                  chk_eq("readout_size", 64'(readout_size), 64'(e.size));
                  chk_eq("timeout_count", 64'(timeout_count), 64'(e.toc));
                  chk_eq("error_timeout", 64'(error_timeout), 64'(e.err));
                  chk_eq("grants_in_event", 64'(gseen), 64'(e.ngr));
                  chk_eq("state_at_done", 64'(state), 64'd0);
                  if (e.ngr > 0)
                     chk_eq("done_latency", 64'(cyc - drop_cyc), 64'd1);
                  else
                     chk_eq("done_latency_nogrant", 64'(cyc - rf_cyc), e.empty ? 64'd0 : 64'd1);
               end
               done_cyc = cyc;
            end
            if (cyc == done_cyc + 1) begin
               chk_eq("ready_after_done", 64'(readout_ready), 64'd1);
               chk_eq("done_single_pulse", 64'(readout_done), 64'd0);
            end
            prev_req   = chan_req;
            prev_ready = readout_ready;
         end
      end
   end

   initial begin : stim
      int n;
      reset_n = 1'b0; chan_en = '0; initiate_readout = 1'b0; send_empty_event = 1'b0;
      m_toc = '0; m_err = 1'b0;
      cfg_default();
      repeat (4) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;

      cfg_burst[0] = 23'd100; cfg_burst[2] = 23'd200; cfg_burst[4] = 23'd300;
      issue(5'b10101, 0, 0); wait_event(0);

      issue(5'b11111, 1, 0); wait_event(0);

      cfg_default(); cfg_burst[0] = 23'd55;
      issue(5'b00001, 2, 0); wait_event(0);

      cfg_default(); cfg_to[0] = 1'b1; cfg_burst[1] = 23'd7; cfg_delay[1] = 5;
      issue(5'b00011, 0, 0); wait_event(0);

      cfg_default();
      for (int i = 0; i < NCHAN; i++) begin
         cfg_burst[i] = 23'h7FFFFF;
         cfg_delay[i] = $urandom_range(1, 15);
      end
      issue(5'b11111, 0, 1); wait_event(1);

      cfg_default(); cfg_delay[1] = 8; cfg_spur[1] = 1'b1; cfg_burst[1] = 23'd11; cfg_burst[2] = 23'd22;
      issue(5'b00110, 0, 1); wait_event(1);

      // Reset while channel 3 is being waited on: event is abandoned, counters clear
      cfg_default(); cfg_delay[3] = 14; cfg_burst[3] = 23'd9; cfg_burst[4] = 23'd9;
      issue(5'b11000, 0, 0);
      n = 0;
      while (!chan_req[3] && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk_eq("reset_test_grant3", 64'(chan_req[3]), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b0;
      ev_q.delete(); gq.delete();
      m_toc = '0; m_err = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;

      repeat (40) begin
         cfg_random();
         issue(NCHAN'($urandom), ($urandom_range(0, 9) == 0) ? 1 : (($urandom_range(0, 9) == 0) ? 2 : 0), 1);
         wait_event(1);
      end

      repeat (5) @(posedge clk);
      #1;
      chk_eq("grants_left", 64'(gq.size()), 64'd0);
      chk_eq("events_left", 64'(ev_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
